// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display path.
package display_pkg;

   localparam int unsigned DIGIT_W  = 4;
   localparam int unsigned AN_MAX_W = 64;

   typedef logic [DIGIT_W-1:0] digit_t;

   // Active-low anode pattern with every digit dark; slice to the digit count in use.
   localparam logic [AN_MAX_W-1:0] AN_OFF = '1;

endpackage : display_pkg

// File: rtl/scan_tick_gen.sv
// Digit-slot prescaler: tick_o is high on the last enabled cycle of each slot.
module scan_tick_gen #(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int unsigned       CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick_o = en_i && (cnt_q == CNT_MAX);

   // Count enabled cycles, wrapping at the end of a slot; hold while disabled.
   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         cnt_d = tick_o ? '0 : cnt_q + 1'b1;
      end
   end

   // Prescaler register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : scan_tick_gen

// File: rtl/display_scanner.sv
// Time-multiplexes N_DIGITS BCD digits onto one decoder with active-low anodes.
// Incoming data is double-buffered and only committed at a frame boundary.
module display_scanner
   import display_pkg::*;
#(
   parameter int unsigned N_DIGITS = 4,
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned BLANK_LZ = 1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [DIGIT_W*N_DIGITS-1:0]   data_i,
   input  logic                          load_i,
   input  logic                          en_i,
   output logic [DIGIT_W-1:0]            bcd_o,
   output logic [N_DIGITS-1:0]           an_o,
   output logic                          load_ack_o
);

   localparam int unsigned            IDX_W    = $clog2(N_DIGITS);
   localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(N_DIGITS - 1);
   localparam logic [N_DIGITS-1:0]    AN_OFF_N = AN_OFF[N_DIGITS-1:0];

   logic                              tick;
   logic                              frame_end;
   logic                              commit;

   logic [IDX_W-1:0]                  idx_q, idx_d;
   digit_t [N_DIGITS-1:0]             pend_q, pend_d;
   logic                              pend_valid_q, pend_valid_d;
   digit_t [N_DIGITS-1:0]             active_q, active_d;

   logic [N_DIGITS-1:0]               blank;
   logic                              nonzero_above;

   digit_t                            bcd_q, bcd_d;
   logic [N_DIGITS-1:0]               an_q, an_d;
   logic                              ack_q, ack_d;

   scan_tick_gen #(
      .SCAN_DIV (SCAN_DIV)
   ) u_tick (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (en_i),
      .tick_o (tick)
   );

   assign frame_end = tick && (idx_q == IDX_LAST);
   assign commit    = frame_end && pend_valid_q;

   // Digit index, double buffer and commit handshake.
   // A load coinciding with a commit becomes the next pending value, so
   // pend_valid stays set; the commit itself always uses the old pending data.
   always_comb begin
      idx_d        = idx_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      active_d     = active_q;
      ack_d        = commit;
      if (tick) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      if (commit) begin
         active_d     = pend_q;
         pend_valid_d = 1'b0;
      end
      if (load_i) begin
         pend_d       = data_i;
         pend_valid_d = 1'b1;
      end
   end

   // Leading-zero mask: digit k>=1 is dark when it and every higher digit are zero.
   always_comb begin
      blank         = '0;
      nonzero_above = 1'b0;
      for (int unsigned k = N_DIGITS - 1; k >= 1; k--) begin
         nonzero_above = nonzero_above || (active_q[IDX_W'(k)] != '0);
         blank[IDX_W'(k)] = (BLANK_LZ != 0) && !nonzero_above;
      end
   end

   // Output pattern for the currently selected digit, registered below.
   always_comb begin
      bcd_d = active_q[idx_q];
      an_d  = AN_OFF_N;
      if (en_i && !blank[idx_q]) begin
         an_d[idx_q] = 1'b0;
      end
   end

   // All scanner state and registered outputs, synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idx_q        <= '0;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         active_q     <= '0;
         bcd_q        <= '0;
         an_q         <= AN_OFF_N;
         ack_q        <= 1'b0;
      end else begin
         idx_q        <= idx_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         active_q     <= active_d;
         bcd_q        <= bcd_d;
         an_q         <= an_d;
         ack_q        <= ack_d;
      end
   end

   assign bcd_o      = bcd_q;
   assign an_o       = an_q;
   assign load_ack_o = ack_q;

endmodule : display_scanner
